// File: rtl/ifetch_icache.sv
// Instruction-fetch front end with a direct-mapped, read-only instruction cache.
// It fetches sequentially at PC+4 and hands one 32-bit word per cycle to the
// decoder on a hit. On a miss it requests the 64-byte line from the memory
// controller and waits for the fill. A ROB rollback redirects the fetch PC.
module ifetch_icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rollback,
    input  logic [31:0]  rollback_pc,
    input  logic         stall,
    output logic         inst_config,
    output logic [31:0]  inst_PC,
    input  logic [511:0] inst_row,
    input  logic         inst_out_config,
    output logic         inst_valid,
    output logic [31:0]  inst_out,
    output logic [31:0]  inst_pc
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - 6 - INDEX_BITS;

    typedef enum logic {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } state_t;

    state_t                  state;
    logic [31:0]             pc;
    logic [LINES-1:0]        line_vld;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [511:0]            data_mem [LINES];

    logic [INDEX_BITS-1:0]   pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic [31:0]             hit_word;
    logic                    fill_en;
    logic                    unused_pc_bits;

    // Lookup of the current PC and decode of the pending fill address.
    always_comb begin
        pc_idx   = pc[6 +: INDEX_BITS];
        pc_tag   = pc[31 -: TAG_W];
        fill_idx = inst_PC[6 +: INDEX_BITS];
        fill_tag = inst_PC[31 -: TAG_W];
        hit      = line_vld[pc_idx] && (tag_mem[pc_idx] == pc_tag);
        hit_word = data_mem[pc_idx][{pc[5:2], 5'b0} +: 32];
        // A fill is taken only while a request is outstanding. A rollback
        // in the same cycle still writes it, because the data matches inst_PC.
        fill_en  = rdy && (state == MISS) && inst_out_config;
    end

    // pc[1:0] is assumed zero and never selects anything.
    assign unused_pc_bits = ^pc[1:0];

    // Line data and tags. No reset: they are qualified by line_vld.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_idx] <= inst_row;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // Line valid bits. Reset is the only invalidation; fills set them.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_vld <= '0;
        end else if (fill_en) begin
            line_vld[fill_idx] <= 1'b1;
        end
    end

    // Fetch control FSM. Priority is rollback, then fill, then hit issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOOKUP;
            pc          <= 32'h0;
            inst_config <= 1'b0;
            inst_PC     <= 32'h0;
            inst_valid  <= 1'b0;
            inst_out    <= 32'h0;
            inst_pc     <= 32'h0;
        end else if (!rdy) begin
            inst_valid <= 1'b0;
        end else if (rollback) begin
            pc          <= rollback_pc;
            inst_valid  <= 1'b0;
            inst_config <= 1'b0;
            state       <= LOOKUP;
        end else begin
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        if (!stall) begin
                            inst_out   <= hit_word;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                        end else begin
                            inst_valid <= 1'b0;
                        end
                    end else begin
                        inst_config <= 1'b1;
                        inst_PC     <= {pc[31:6], 6'b0};
                        inst_valid  <= 1'b0;
                        state       <= MISS;
                    end
                end
                MISS: begin
                    inst_valid <= 1'b0;
                    if (inst_out_config) begin
                        inst_config <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                default: begin
                    state <= LOOKUP;
                end
            endcase
        end
    end

endmodule
